// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// START/DONE handshake; divide-by-zero short-circuits straight to DONE.
module restoring_divider #(
  parameter int unsigned N = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [N-1:0] DIVIDEND,
  input  logic [N-1:0] DIVISOR,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         BUSY,
  output logic         DONE,
  output logic         DZ
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  v_q, v_d;
  // Partial remainder is always < divisor, so its top bit is never set and
  // only N bits are stored; the trial subtraction itself is N+1 bits wide.
  logic [N-1:0]  p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          dz_q, dz_d;

  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic          qbit;
  logic [N-1:0]  d_next;
  logic [N-1:0]  p_next;

  // Subtract path as A + ~B + 1; negative result means restore.
  assign shifted = {p_q, d_q[N-1]};
  assign diff    = shifted + ~{1'b0, v_q} + {{N{1'b0}}, 1'b1};
  assign qbit    = ~diff[N];
  assign d_next  = {d_q[N-2:0], qbit};
  assign p_next  = qbit ? diff[N-1:0] : shifted[N-1:0];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      v_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      v_q     <= v_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    v_d     = v_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (START) begin
          d_d   = DIVIDEND;
          v_d   = DIVISOR;
          p_d   = '0;
          cnt_d = '0;
          if (DIVISOR != '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = DIVIDEND;
            dz_d    = 1'b1;
          end
        end
      end
      S_RUN: begin
        d_d   = d_next;
        p_d   = p_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          q_d     = d_next;
          r_d     = p_next;
          dz_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign DZ   = dz_q;
  assign BUSY = (state_q == S_RUN);
  assign DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider (N=4) with an
// exhaustive operand sweep at the end.
module tb_restoring_divider;

  localparam int unsigned N = 4;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic [N-1:0] DIVIDEND;
  logic [N-1:0] DIVISOR;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         BUSY;
  logic         DONE;
  logic         DZ;

  int tests = 0;
  int fails = 0;

  restoring_divider #(.N(N)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .DIVIDEND (DIVIDEND),
    .DIVISOR  (DIVISOR),
    .Q        (Q),
    .R        (R),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .DZ       (DZ)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one START and waits (bounded) for DONE, checking latency and result.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic edz, input string tag);
    int   k;
    logic busy_ok;
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    step();
    START    = 1'b0;
    k        = 0;
    busy_ok  = 1'b1;
    while (DONE !== 1'b1 && k < 3 * N) begin
      if (BUSY !== 1'b1) busy_ok = 1'b0;
      step();
      k++;
    end
    chk({tag, " done"}, {31'd0, DONE}, 32'd1);
    chk({tag, " latency"}, k, (b == '0) ? 0 : N);
    chk({tag, " busy while running"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " busy at done"}, {31'd0, BUSY}, 32'd0);
    chk({tag, " Q"}, {28'd0, Q}, {28'd0, eq});
    chk({tag, " R"}, {28'd0, R}, {28'd0, er});
    chk({tag, " DZ"}, {31'd0, DZ}, {31'd0, edz});
  endtask

  initial begin
    int pulses;
    RST_N    = 1'b0;
    START    = 1'b0;
    DIVIDEND = '0;
    DIVISOR  = '0;
    step();
    step();
    chk("reset Q", {28'd0, Q}, 32'd0);
    chk("reset R", {28'd0, R}, 32'd0);
    chk("reset BUSY", {31'd0, BUSY}, 32'd0);
    chk("reset DONE", {31'd0, DONE}, 32'd0);
    chk("reset DZ", {31'd0, DZ}, 32'd0);
    RST_N = 1'b1;
    step();

    run_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, "13/3");
    step();
    chk("13/3 done is one cycle", {31'd0, DONE}, 32'd0);
    chk("13/3 idle busy", {31'd0, BUSY}, 32'd0);

    run_div(4'd15, 4'd1,  4'd15, 4'd0, 1'b0, "15/1");
    run_div(4'd7,  4'd9,  4'd0,  4'd7, 1'b0, "7/9");
    run_div(4'd15, 4'd15, 4'd1,  4'd0, 1'b0, "15/15");
    run_div(4'd0,  4'd5,  4'd0,  4'd0, 1'b0, "0/5");
    run_div(4'd8,  4'd2,  4'd4,  4'd0, 1'b0, "8/2");

    run_div(4'd6, 4'd0, 4'd15, 4'd6, 1'b1, "6/0");
    run_div(4'd9, 4'd4, 4'd2,  4'd1, 1'b0, "9/4 after dz");

    // START pulses with 1/1 during the run of 14/3 must be ignored.
    DIVIDEND = 4'd14;
    DIVISOR  = 4'd3;
    START    = 1'b1;
    step();
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      START = (k == 2 || k == 3);
      if (START) begin
        DIVIDEND = 4'd1;
        DIVISOR  = 4'd1;
      end
      step();
      if (DONE === 1'b1) pulses++;
      if (k == 1) chk("14/3 Q held during run", {28'd0, Q}, 32'd2);
      if (k == N) begin
        chk("14/3 done nominal", {31'd0, DONE}, 32'd1);
        chk("14/3 Q", {28'd0, Q}, 32'd4);
        chk("14/3 R", {28'd0, R}, 32'd2);
      end
    end
    START = 1'b0;
    chk("14/3 single done pulse", pulses, 32'd1);

    // START held high: second operation accepted in the DONE cycle.
    DIVIDEND = 4'd12;
    DIVISOR  = 4'd5;
    START    = 1'b1;
    step();
    DIVIDEND = 4'd11;
    DIVISOR  = 4'd2;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == N) begin
        chk("b2b first done", {31'd0, DONE}, 32'd1);
        chk("b2b first Q", {28'd0, Q}, 32'd2);
        chk("b2b first R", {28'd0, R}, 32'd2);
      end
      if (k == N + 1) begin
        chk("b2b no dead cycle busy", {31'd0, BUSY}, 32'd1);
        chk("b2b no dead cycle done", {31'd0, DONE}, 32'd0);
      end
      if (k == 2 * N + 1) begin
        chk("b2b second done", {31'd0, DONE}, 32'd1);
        chk("b2b second Q", {28'd0, Q}, 32'd5);
        chk("b2b second R", {28'd0, R}, 32'd1);
        START = 1'b0;
      end
      if (k == 2 * N + 2) begin
        chk("b2b back to idle done", {31'd0, DONE}, 32'd0);
        chk("b2b back to idle busy", {31'd0, BUSY}, 32'd0);
      end
    end

    // Reset in the middle of a run aborts it without a DONE pulse.
    DIVIDEND = 4'd13;
    DIVISOR  = 4'd3;
    START    = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    chk("abort BUSY", {31'd0, BUSY}, 32'd0);
    chk("abort DONE", {31'd0, DONE}, 32'd0);
    chk("abort Q", {28'd0, Q}, 32'd0);
    chk("abort R", {28'd0, R}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (DONE === 1'b1) pulses++;
    end
    chk("abort no done", pulses, 32'd0);
    run_div(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, "10/3 after abort");

    for (int unsigned a = 0; a < 16; a++) begin
      for (int unsigned b = 0; b < 16; b++) begin
        logic [N-1:0] eq;
        logic [N-1:0] er;
        eq = (b == 0) ? 4'd15 : 4'(a / b);
        er = (b == 0) ? 4'(a) : 4'(a % b);
        run_div(4'(a), 4'(b), eq, er, (b == 0), "sweep");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
